spi_master: RTL and testbench

//  SPI bus master: serialises one DATA_W-bit word on mosi and captures DATA_W bits from miso.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_sclk_gen.sv | 56 +++++
 rtl/spi_master.sv | 172 +++++++++++++++++
 tb/tb_spi_master.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and the slave.
//   spi_state_e : FSM state encodings (idle, load, shift, stop)
//   Mode0..Mode3: SPI mode constants, bit1 = CPOL, bit0 = CPHA
//   cpol()/cpha(): decode a 2-bit mode into clock polarity / phase
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StLoad  = 3'b001,
    StShift = 3'b010,
    StStop  = 3'b011
  } spi_state_e;

  localparam logic [1:0] Mode0 = 2'b00;
  localparam logic [1:0] Mode1 = 2'b01;
  localparam logic [1:0] Mode2 = 2'b10;
  localparam logic [1:0] Mode3 = 2'b11;

  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: divides clk_i down to sclk and counts sclk edges.
//   clk_i, rst_ni : system clock, asynchronous active-low reset
//   en_i          : run the divider; while low sclk parks at cpol_i and counters clear
//   cpol_i        : idle level of sclk
//   sclk_o        : registered SPI clock
//   lead_pulse_o  : this clk edge produces a leading sclk edge (1st, 3rd, ...)
//   trail_pulse_o : this clk edge produces a trailing sclk edge (2nd, 4th, ...)
//   last_edge_o   : this clk edge produces edge number 2*DATA_W
module spi_sclk_gen #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic cpol_i,
  output logic sclk_o,
  output logic lead_pulse_o,
  output logic trail_pulse_o,
  output logic last_edge_o
);

  localparam int unsigned DivW  = $clog2(CLK_DIV);
  localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);

  logic [DivW-1:0]  div_q;
  logic [EdgeW-1:0] edge_cnt_q;
  logic             sclk_q;
  logic             tick;

  assign tick          = en_i && (div_q == DivW'(CLK_DIV - 1));
  // Edges are numbered from zero internally, so even counts are leading edges.
  assign lead_pulse_o  = tick && !edge_cnt_q[0];
  assign trail_pulse_o = tick && edge_cnt_q[0];
  assign last_edge_o   = tick && (edge_cnt_q == EdgeW'(2 * DATA_W - 1));
  assign sclk_o        = sclk_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q      <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
    end else if (!en_i) begin
      div_q      <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= cpol_i;
    end else if (tick) begin
      div_q      <= '0;
      edge_cnt_q <= edge_cnt_q + EdgeW'(1);
      sclk_q     <= ~sclk_q;
    end else begin
      div_q      <= div_q + DivW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI bus master: sends one DATA_W-bit word on mosi while capturing DATA_W bits from miso.
// Supports all four CPOL/CPHA modes; host side is a start/done handshake on clk_i.
//   clk_i, rst_ni    : system clock, asynchronous active-low reset (aborts any transfer)
//   start_i          : request a transfer, sampled only while idle
//   mode_i           : {CPOL, CPHA}, latched when start is accepted
//   tx_data_i        : word to send, latched when start is accepted
//   rx_data_o        : last received word, updated with done_o
//   busy_o           : transfer in progress
//   done_o           : one-cycle completion pulse
//   sclk_o, mosi_o, cs_n_o : registered SPI outputs; miso_i : SPI input
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift bit 0 out first and place the first
// received bit in rx_data_o[0]. Default is MSB first; timing is identical either way.
module spi_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_n_o
);

  import spi_pkg::*;

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] CntMax = DivW'(CLK_DIV - 1);

  spi_state_e        state_q;
  logic [1:0]        mode_q;
  logic [DivW-1:0]   cnt_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              mosi_q;
  logic              cs_n_q;
  logic              busy_q;
  logic              done_q;

  logic              gen_cpol;
  logic              lead_pulse;
  logic              trail_pulse;
  logic              last_edge;
  logic              drive_edge;
  logic              sample_edge;

  // Bit-order dependent views of the shift registers.
  logic              load_bit;
  logic [DATA_W-1:0] load_rest;
  logic              tx_bit;
  logic [DATA_W-1:0] tx_rest;
  logic [DATA_W-1:0] rx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign load_bit  = tx_data_i[0];
  assign load_rest = tx_data_i >> 1;
  assign tx_bit    = tx_sr_q[0];
  assign tx_rest   = tx_sr_q >> 1;
  assign rx_next   = {miso_i, rx_sr_q[DATA_W-1:1]};
`else
  assign load_bit  = tx_data_i[DATA_W-1];
  assign load_rest = tx_data_i << 1;
  assign tx_bit    = tx_sr_q[DATA_W-1];
  assign tx_rest   = tx_sr_q << 1;
  assign rx_next   = {rx_sr_q[DATA_W-2:0], miso_i};
`endif

  // While idle sclk follows the live mode input so it already sits at CPOL before cs_n falls.
  assign gen_cpol = (state_q == StIdle) ? cpol(mode_i) : cpol(mode_q);

  // CPHA=0 puts the first bit out on entry to LOAD, so the final trailing edge has nothing new.
  assign drive_edge  = cpha(mode_q) ? lead_pulse : (trail_pulse && !last_edge);
  assign sample_edge = cpha(mode_q) ? trail_pulse : lead_pulse;

  spi_sclk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (state_q == StShift),
    .cpol_i        (gen_cpol),
    .sclk_o        (sclk_o),
    .lead_pulse_o  (lead_pulse),
    .trail_pulse_o (trail_pulse),
    .last_edge_o   (last_edge)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      mode_q    <= Mode0;
      cnt_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cs_n_q <= 1'b1;
          busy_q <= 1'b0;
          if (start_i) begin
            state_q <= StLoad;
            mode_q  <= mode_i;
            cnt_q   <= '0;
            rx_sr_q <= '0;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            if (cpha(mode_i)) begin
              tx_sr_q <= tx_data_i;
            end else begin
              mosi_q  <= load_bit;
              tx_sr_q <= load_rest;
            end
          end
        end
        StLoad: begin
          if (cnt_q == CntMax) begin
            cnt_q   <= '0;
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + DivW'(1);
          end
        end
        StShift: begin
          if (drive_edge) begin
            mosi_q  <= tx_bit;
            tx_sr_q <= tx_rest;
          end
          if (sample_edge) begin
            rx_sr_q <= rx_next;
          end
          if (last_edge) begin
            state_q <= StStop;
          end
        end
        StStop: begin
          if (cnt_q == CntMax) begin
            cnt_q     <= '0;
            state_q   <= StIdle;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            rx_data_q <= rx_sr_q;
          end else begin
            cnt_q <= cnt_q + DivW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_data_o = rx_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign mosi_o    = mosi_q;
  assign cs_n_o    = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;
  import spi_pkg::*;

  localparam int DW   = 8;
  localparam int DIV  = 4;
  localparam int LAT  = 1 + DIV + 2 * DW * DIV + DIV;     // 73
  localparam int DIV2 = 2;
  localparam int LAT2 = 1 + DIV2 + 2 * DW * DIV2 + DIV2;  // 37

  typedef struct {
    logic [DW-1:0] rx;
    logic [DW-1:0] word;
    int            t0;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] tx = '0;
  logic [DW-1:0] rx;
  logic          busy, done, sclk, mosi, cs_n;
  logic          miso = 1'b0;

  logic          start2 = 1'b0;
  logic [DW-1:0] tx2 = '0;
  logic [DW-1:0] rx2;
  logic          busy2, done2, sclk2, mosi2, cs_n2;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t exp2_q[$];

  // Slave model state
  logic [1:0]    slv_mode = 2'b00;
  logic [DW-1:0] slv_word = '0;
  logic [DW-1:0] s_word = '0;
  logic [DW-1:0] cap = '0;
  logic          prev_cs = 1'b1;
  logic          prev_sclk = 1'b0;
  int            s_edges = 0;
  int            s_idx = 0;

  spi_master #(.DATA_W(DW), .CLK_DIV(DIV)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .tx_data_i(tx),
    .rx_data_o(rx), .busy_o(busy), .done_o(done), .sclk_o(sclk), .mosi_o(mosi),
    .miso_i(miso), .cs_n_o(cs_n)
  );

  // Second instance: fast divider, mode 0, miso looped back from mosi.
  spi_master #(.DATA_W(DW), .CLK_DIV(DIV2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .mode_i(2'b00), .tx_data_i(tx2),
    .rx_data_o(rx2), .busy_o(busy2), .done_o(done2), .sclk_o(sclk2), .mosi_o(mosi2),
    .miso_i(mosi2), .cs_n_o(cs_n2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic out_bit(input logic [DW-1:0] w, input int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return w[k];
`else
    return w[DW-1-k];
`endif
  endfunction

  function automatic logic [DW-1:0] cap_bit(input logic [DW-1:0] c, input logic b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {b, c[DW-1:1]};
`else
    return {c[DW-2:0], b};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // SPI slave model: watches the DUT pins just after each clk edge.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      prev_cs = 1'b1;
      miso    = 1'b0;
    end else begin
      if (!cs_n && prev_cs) begin
        s_word  = slv_word;
        s_edges = 0;
        s_idx   = 0;
        cap     = '0;
        if (!slv_mode[0]) miso = out_bit(s_word, 0);
      end else if (!cs_n && (sclk != prev_sclk)) begin
        s_edges++;
        if (s_edges % 2 == 1) begin
          if (slv_mode[0]) begin
            miso = out_bit(s_word, s_idx);
            s_idx++;
          end else begin
            cap = cap_bit(cap, mosi);
          end
        end else begin
          if (slv_mode[0]) begin
            cap = cap_bit(cap, mosi);
          end else begin
            s_idx++;
            if (s_idx < DW) miso = out_bit(s_word, s_idx);
          end
        end
      end
      prev_cs   = cs_n;
      prev_sclk = sclk;
    end
  end

  // Scoreboard monitor
  always begin
    exp_t e;
    @(negedge clk);
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done=1 got, required no pending transfer");
      end else begin
        e = exp_q.pop_front();
        check("rx_data", 32'(rx), 32'(e.rx));
        check("mosi_word", 32'(cap), 32'(e.word));
        check("latency", 32'(cyc - e.t0), 32'(LAT));
        check("cs_n_at_done", 32'(cs_n), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
    if (rst_n && done2) begin
      if (exp2_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done2: done=1 got, required no pending transfer");
      end else begin
        e = exp2_q.pop_front();
        check("rx_data2", 32'(rx2), 32'(e.rx));
        check("latency2", 32'(cyc - e.t0), 32'(LAT2));
      end
    end
  end

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: %0d transfers pending, required 0", exp_q.size() + exp2_q.size());
      exp_q.delete();
      exp2_q.delete();
    end
  endtask

  task automatic run_xfer(input logic [1:0] m, input logic [DW-1:0] t, input logic [DW-1:0] s);
    exp_t e;
    @(posedge clk);
    #1;
    mode     = m;
    slv_mode = m;
    slv_word = s;
    @(posedge clk);
    #1;
    start  = 1'b1;
    tx     = t;
    e.rx   = s;
    e.word = t;
    e.t0   = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [1:0] mm;
    logic first_exp;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cs_n", 32'(cs_n), 32'd1);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rx", 32'(rx), 32'd0);
    check("reset_cs_n2", 32'(cs_n2), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Mode 0 basic transfer
    run_xfer(Mode0, 8'hA5, 8'h3C);
    wait_drained(200);

    // Modes 1..3, and sclk idles at CPOL afterwards
    for (int m = 1; m < 4; m++) begin
      mm = 2'(m);
      run_xfer(mm, 8'h81, 8'h7E);
      wait_drained(200);
      repeat (2) @(negedge clk);
      check("idle_sclk", 32'(sclk), 32'(cpol(mm)));
    end

    // start re-pulsed mid-transfer with new tx_data: ignored
    run_xfer(Mode0, 8'h5A, 8'hC3);
    repeat (19) @(posedge clk);
    #1;
    check("busy_mid", 32'(busy), 32'd1);
    start = 1'b1;
    tx    = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drained(200);
    repeat (LAT + 10) @(posedge clk);

    // Reset at cycle 30 of a transfer
    run_xfer(Mode0, 8'h33, 8'hCC);
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx", 32'(rx), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LAT + 10) @(posedge clk);
    run_xfer(Mode0, 8'h96, 8'h69);
    wait_drained(200);

    // start held high: two back-to-back transfers
    @(posedge clk);
    #1;
    mode     = Mode0;
    slv_mode = Mode0;
    slv_word = 8'hAA;
    @(posedge clk);
    #1;
    start  = 1'b1;
    tx     = 8'h11;
    e.rx   = 8'hAA;
    e.word = 8'h11;
    e.t0   = cyc;
    exp_q.push_back(e);
    e.rx   = 8'h55;
    e.word = 8'h22;
    e.t0   = cyc + LAT;
    exp_q.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    tx       = 8'h22;
    slv_word = 8'h55;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drained(300);

    // Fast divider instance, loopback
    @(posedge clk);
    #1;
    start2 = 1'b1;
    tx2    = 8'h01;
    e.rx   = 8'h01;
    e.word = 8'h01;
    e.t0   = cyc;
    exp2_q.push_back(e);
    @(posedge clk);
    #1;
    start2 = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    first_exp = tx2[0];
`else
    first_exp = tx2[DW-1];
`endif
    check("first_mosi2", 32'(mosi2), 32'(first_exp));
    wait_drained(200);
    repeat (10) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
